// File: rtl/binary_to_bcd.sv
// ============================================================================
// Module   : binary_to_bcd
// Purpose  : Sequential shift-and-add-3 binary to packed-decimal converter
//            with a start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_bcd #(
   parameter int WIDTH  = 26,
   parameter int DIGITS = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [WIDTH-1:0] binary_value,
   output logic             ready,
   output logic             done,
   output logic [3:0]       BCD_value [DIGITS-1:0]
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD3  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    shift_reg;
   logic [4*DIGITS-1:0] scratch;
   logic [CNT_W-1:0]    bit_cnt;

   logic [4*DIGITS-1:0] scratch_adj;
   logic [4*DIGITS-1:0] scratch_shl;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         assign scratch_adj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ?
                                        scratch[4*g +: 4] + 4'd3 :
                                        scratch[4*g +: 4];
      end
   endgenerate

   // The binary MSB feeds the units digit as the whole {scratch, shift_reg} moves left.
   assign scratch_shl = {scratch[4*DIGITS-2:0], shift_reg[WIDTH-1]};

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         ready     <= 1'b1;
         done      <= 1'b0;
         shift_reg <= '0;
         scratch   <= '0;
         bit_cnt   <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            BCD_value[i] <= 4'd0;
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shift_reg <= binary_value;
                  scratch   <= '0;
                  bit_cnt   <= CNT_W'(WIDTH);
                  ready     <= 1'b0;
                  state     <= ADD3;
               end
            end
            ADD3: begin
               scratch <= scratch_adj;
               state   <= SHIFT;
            end
            SHIFT: begin
               scratch   <= scratch_shl;
               shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
               bit_cnt   <= bit_cnt - 1'b1;
               if (bit_cnt == CNT_W'(1)) begin
                  // Publish the final shifted value so the outputs never show partial results.
                  for (int i = 0; i < DIGITS; i++) begin
                     BCD_value[i] <= scratch_shl[4*i +: 4];
                  end
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= ADD3;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd.sv
// ============================================================================
// Module   : tb_binary_to_bcd
// Purpose  : Scoreboard bench for binary_to_bcd (results, latency, handshake,
//            back-to-back restart and asynchronous reset abort).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_to_bcd;

   localparam int WIDTH   = 26;
   localparam int DIGITS  = 8;
   localparam int LATENCY = 52;

   logic             clk;
   logic             rstN;
   logic             start;
   logic [WIDTH-1:0] binary_value;
   logic             ready;
   logic             done;
   logic [3:0]       bcd [DIGITS-1:0];

   typedef struct {
      logic [31:0] exp;
      int          cyc;
   } sb_t;

   sb_t sb [$];
   sb_t mon_e;
   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fails  = 0;

   binary_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk          (clk),
      .rstN         (rstN),
      .start        (start),
      .binary_value (binary_value),
      .ready        (ready),
      .done         (done),
      .BCD_value    (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] packed_out();
      logic [31:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = bcd[i];
      return r;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest accepted operand.
   always @(negedge clk) begin
      if (rstN && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'(done), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("bcd_value", 64'(packed_out()), 64'(mon_e.exp));
            check("latency", 64'(cyc - mon_e.cyc), 64'(LATENCY));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 64'(ready), 64'd1);
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] v);
      sb_t e;
      e.exp = to_bcd(int'(v));
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_done_and_check();
      int   n;
      logic saw_ready;
      n = 0;
      saw_ready = 1'b0;
      @(negedge clk);
      while (!done && n < 80) begin
         if (ready) saw_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("ready_busy", 64'(saw_ready), 64'd0);
   endtask

   task automatic run_one(input logic [WIDTH-1:0] v);
      wait_ready();
      start = 1'b1;
      binary_value = v;
      @(posedge clk);
      #1;
      push_exp(v);
      start = 1'b0;
      binary_value = WIDTH'($urandom);
      check("ready_drop", 64'(ready), 64'd0);
      wait_done_and_check();
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("ready_back", 64'(ready), 64'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN = 1'b0;
      start = 1'b0;
      binary_value = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_digits", 64'(packed_out()), 64'd0);
      rstN = 1'b1;

      run_one(26'd162);
      run_one(26'd43210);
      run_one(26'd0);
      run_one(26'd67108863);

      // Start held high: the second conversion re-samples the operand at the IDLE edge.
      wait_ready();
      start = 1'b1;
      binary_value = 26'd1234567;
      @(posedge clk);
      #1;
      push_exp(26'd1234567);
      repeat (10) @(posedge clk);
      binary_value = 26'd7654321;
      wait_done_and_check();
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_idle", 64'(ready), 64'd1);
      @(posedge clk);
      #1;
      push_exp(26'd7654321);
      start = 1'b0;
      check("b2b_restart", 64'(ready), 64'd0);
      wait_done_and_check();
      @(negedge clk);
      check("b2b_done_pulse", 64'(done), 64'd0);

      // Asynchronous reset 20 cycles into a conversion aborts it without a done pulse.
      wait_ready();
      start = 1'b1;
      binary_value = 26'd999999;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_done", 64'(done), 64'd0);
      check("abort_digits", 64'(packed_out()), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (70) @(negedge clk);
      check("abort_idle_ready", 64'(ready), 64'd1);

      for (int i = 0; i < 10; i++) begin
         run_one(WIDTH'($urandom_range(0, 67108863)));
      end

      repeat (5) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
